// File: rtl/gc_dispatcher_pkg.sv
// gc_dispatcher_pkg: shared widths, dispatcher state type and loop-bound test.
package gc_dispatcher_pkg;
  localparam int N_CORE = 4;
  localparam int GC_WIDTH = 32;
  localparam int GD_WIDTH = 32;
  localparam int PL_W = 128;
  typedef enum logic [1:0] {IDLE, RUN, EXH} dispatch_state_t;
  // Callers sign-extend into PL_W so one function serves any configured width.
  function automatic logic past_limit(input logic signed [PL_W-1:0] v,
                                      input logic signed [PL_W-1:0] limit,
                                      input logic gd_neg);
    return gd_neg ? (v <= limit) : (v >= limit);
  endfunction
endpackage

// File: rtl/gc_prefix_count.sv
// gc_prefix_count: exclusive prefix popcount of a request vector plus its total.
module gc_prefix_count #(
  parameter int N = 4,
  parameter int CW = 3
) (
  input  logic [N-1:0]         req,
  output logic [N-1:0][CW-1:0] k,
  output logic [CW-1:0]        n
);
  logic [CW-1:0] acc;
  always_comb begin
    acc = '0;
    k = '0;
    for (int i = 0; i < N; i++) begin
      k[i] = acc;
      acc = acc + CW'(req[i]);
    end
    n = acc;
  end
endmodule

// File: rtl/gc_dispatcher.sv
// gc_dispatcher: hands each requesting core a unique loop index gc + k*gd after a fork.
module gc_dispatcher #(
  parameter int N_CORE = gc_dispatcher_pkg::N_CORE,
  parameter int GC_WIDTH = gc_dispatcher_pkg::GC_WIDTH,
  parameter int GD_WIDTH = gc_dispatcher_pkg::GD_WIDTH
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             fork_valid,
  input  logic [GC_WIDTH-1:0]              fork_gc,
  input  logic [GD_WIDTH-1:0]              fork_gd,
  input  logic [GC_WIDTH-1:0]              fork_limit,
  input  logic [N_CORE-1:0]                req_valid,
  output logic [N_CORE-1:0]                req_ready,
  output logic [N_CORE-1:0][GC_WIDTH-1:0]  gc_out,
  output logic [N_CORE-1:0]                exhausted,
  output logic                             running,
  output logic                             all_done
);
  import gc_dispatcher_pkg::*;
  localparam int CW = $clog2(N_CORE + 1);
  localparam int EXT = GC_WIDTH + GD_WIDTH + CW + 1;
  dispatch_state_t state, state_nxt;
  logic [GC_WIDTH-1:0] gc, gc_nxt, limit;
  logic [GD_WIDTH-1:0] gd;
  logic [N_CORE-1:0] done_mask;
  logic [N_CORE-1:0][CW-1:0] k;
  logic [CW-1:0] n;
  logic signed [EXT-1:0] gc_x, gd_x, lim_x, nxt_x, fgc_x, flim_x;
  logic signed [EXT-1:0] v [N_CORE];
  gc_prefix_count #(.N(N_CORE), .CW(CW)) u_pc (.req(req_valid), .k(k), .n(n));
  assign gc_x = EXT'($signed(gc));
  assign gd_x = EXT'($signed(gd));
  assign lim_x = EXT'($signed(limit));
  assign fgc_x = EXT'($signed(fork_gc));
  assign flim_x = EXT'($signed(fork_limit));
  assign nxt_x = gc_x + $signed(EXT'(n)) * gd_x;
  assign running = state == RUN;
  assign all_done = state == EXH && &done_mask;
  always_comb begin
    req_ready = (state != IDLE && !fork_valid) ? '1 : '0;
    for (int i = 0; i < N_CORE; i++) begin
      v[i] = gc_x + $signed(EXT'(k[i])) * gd_x;
      gc_out[i] = state == EXH ? gc : state == RUN ? v[i][GC_WIDTH-1:0] : '0;
      exhausted[i] = req_valid[i] && req_ready[i] &&
                     (state == EXH || past_limit(PL_W'(v[i]), PL_W'(lim_x), gd[GD_WIDTH-1]));
    end
    // Entering EXH keeps the truncated next gc; EXH itself freezes it.
    state_nxt = fork_valid ? (past_limit(PL_W'(fgc_x), PL_W'(flim_x), fork_gd[GD_WIDTH-1]) ? EXH : RUN)
              : state == RUN ? (past_limit(PL_W'(nxt_x), PL_W'(lim_x), gd[GD_WIDTH-1]) ? EXH : RUN)
              : state;
    gc_nxt = fork_valid ? fork_gc : state == RUN ? nxt_x[GC_WIDTH-1:0] : gc;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      gc <= '0;
      gd <= '0;
      limit <= '0;
      done_mask <= '0;
    end else begin
      state <= state_nxt;
      gc <= gc_nxt;
      gd <= fork_valid ? fork_gd : gd;
      limit <= fork_valid ? fork_limit : limit;
      done_mask <= fork_valid ? '0 : done_mask | exhausted;
    end
  end
endmodule

// File: tb/tb_gc_dispatcher.sv
// tb_gc_dispatcher: directed vectors checked against a loop-level model every cycle.
module tb_gc_dispatcher;
  logic clk = 1'b0;
  logic reset, fork_valid;
  logic [31:0] fork_gc, fork_gd, fork_limit;
  logic [3:0] req_valid, req_ready, exhausted;
  logic [3:0][31:0] gc_out;
  logic running, all_done;
  int n_checks = 0, n_fail = 0;
  bit chk_en = 1'b0;
  int m_state = 0;
  longint m_gc = 0, m_gd = 0, m_lim = 0;
  logic [3:0] m_done = 4'h0;

  gc_dispatcher dut (.clk(clk), .reset(reset), .fork_valid(fork_valid), .fork_gc(fork_gc),
    .fork_gd(fork_gd), .fork_limit(fork_limit), .req_valid(req_valid), .req_ready(req_ready),
    .gc_out(gc_out), .exhausted(exhausted), .running(running), .all_done(all_done));

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", nm, a, e);
    end
  endtask

  function automatic longint sx(input logic [31:0] x);
    return longint'($signed(x));
  endfunction

  function automatic logic past(input longint val, input longint gd, input longint lim);
    return gd < 0 ? val <= lim : val >= lim;
  endfunction

  // Index handed to core i: start plus one stride per lower-numbered requester.
  function automatic longint idx(input int i);
    longint r = m_gc;
    for (int j = 0; j < i; j++) if (req_valid[j]) r += m_gd;
    return r;
  endfunction

  always @(posedge clk) begin : model
    longint nx;
    logic [3:0] d;
    int st;
    nx = m_gc;
    d = m_done;
    st = m_state;
    if (reset) begin
      st = 0; nx = 0; d = 4'h0;
      m_gd <= 0; m_lim <= 0;
    end else if (fork_valid) begin
      nx = sx(fork_gc); d = 4'h0;
      st = past(nx, sx(fork_gd), sx(fork_limit)) ? 2 : 1;
      m_gd <= sx(fork_gd); m_lim <= sx(fork_limit);
    end else if (m_state == 1) begin
      for (int i = 0; i < 4; i++)
        if (req_valid[i]) begin
          if (past(idx(i), m_gd, m_lim)) d[i] = 1'b1;
          nx += m_gd;
        end
      st = past(nx, m_gd, m_lim) ? 2 : 1;
      nx = sx(nx[31:0]);
    end else if (m_state == 2) d = d | req_valid;
    m_state <= st;
    m_gc <= nx;
    m_done <= d;
  end

  always @(negedge clk) begin : cmp
    logic [3:0] er, ee;
    logic [31:0] eo;
    longint t;
    if (chk_en) begin
      er = (m_state != 0 && !fork_valid) ? 4'hF : 4'h0;
      for (int i = 0; i < 4; i++) begin
        t = idx(i);
        eo = m_state == 2 ? m_gc[31:0] : t[31:0];
        ee[i] = er[i] && req_valid[i] && (m_state == 2 || (m_state == 1 && past(t, m_gd, m_lim)));
        if (er[i] && req_valid[i]) check($sformatf("gc_out[%0d]", i), 64'(gc_out[i]), 64'(eo));
      end
      check("req_ready", 64'(req_ready), 64'(er));
      check("exhausted", 64'(exhausted), 64'(ee));
      check("running", 64'(running), 64'(m_state == 1));
      check("all_done", 64'(all_done), 64'(m_state == 2 && m_done == 4'hF));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set(input logic fv, input logic [31:0] g, input logic [31:0] d,
                     input logic [31:0] l, input logic [3:0] rv);
    fork_valid = fv; fork_gc = g; fork_gd = d; fork_limit = l; req_valid = rv;
  endtask

  initial begin
    reset = 1'b1;
    set(0, 0, 0, 0, 4'h0);
    tick;
    chk_en = 1'b1;
    tick;
    reset = 1'b0;
    @(negedge clk);
    check("rst gc_out0", 64'(gc_out[0]), 64'h0);
    check("rst req_ready", 64'(req_ready), 64'h0);
    // ordering
    tick; set(1, 0, 1, 100, 4'h0);
    tick; set(0, 0, 0, 0, 4'hF);
    @(negedge clk);
    check("t1 c0", 64'(gc_out[0]), 64'd0);
    check("t1 c1", 64'(gc_out[1]), 64'd1);
    check("t1 c3", 64'(gc_out[3]), 64'd3);
    check("t1 exh", 64'(exhausted), 64'h0);
    tick; set(0, 0, 0, 0, 4'b0100);
    @(negedge clk);
    check("t1 c2 next", 64'(gc_out[2]), 64'd4);
    // sparse, negative stride
    tick; set(1, 10, 32'hFFFFFFFD, 32'hFFFFFFFB, 4'h0);
    tick; set(0, 0, 0, 0, 4'b1010);
    @(negedge clk);
    check("t2 c1", 64'(gc_out[1]), 64'd10);
    check("t2 c3", 64'(gc_out[3]), 64'd7);
    tick;
    tick;
    @(negedge clk);
    check("t2 c1 -2", 64'(gc_out[1]), 64'hFFFFFFFE);
    check("t2 c3 -5", 64'(gc_out[3]), 64'hFFFFFFFB);
    check("t2 exh", 64'(exhausted), 64'b1000);
    tick; set(0, 0, 0, 0, 4'h0);
    @(negedge clk);
    check("t2 running", 64'(running), 64'h0);
    // exhaustion and all_done
    tick; set(1, 0, 2, 5, 4'h0);
    tick; set(0, 0, 0, 0, 4'hF);
    @(negedge clk);
    check("t3 c2", 64'(gc_out[2]), 64'd4);
    check("t3 c3", 64'(gc_out[3]), 64'd6);
    check("t3 exh", 64'(exhausted), 64'b1000);
    tick; set(0, 0, 0, 0, 4'b0001);
    @(negedge clk);
    check("t3 frozen", 64'(gc_out[0]), 64'd8);
    check("t3 exh0", 64'(exhausted), 64'b0001);
    tick; set(0, 0, 0, 0, 4'b0110);
    @(negedge clk);
    check("t3 not done", 64'(all_done), 64'h0);
    tick; set(0, 0, 0, 0, 4'h0);
    @(negedge clk);
    check("t3 all_done", 64'(all_done), 64'h1);
    // fork override
    tick; set(1, 0, 1, 1000, 4'h0);
    tick; set(0, 0, 0, 0, 4'hF);
    tick; set(1, 100, 1, 200, 4'hF);
    @(negedge clk);
    check("t4 ready", 64'(req_ready), 64'h0);
    tick; set(0, 0, 0, 0, 4'hF);
    @(negedge clk);
    check("t4 c0", 64'(gc_out[0]), 64'd100);
    check("t4 c3", 64'(gc_out[3]), 64'd103);
    check("t4 all_done", 64'(all_done), 64'h0);
    // wide counter, no signed wrap
    tick; set(1, 32'h7FFFFFF0, 32'h10, 32'h7FFFFFFF, 4'h0);
    tick; set(0, 0, 0, 0, 4'hF);
    @(negedge clk);
    check("t5 c0", 64'(gc_out[0]), 64'h7FFFFFF0);
    check("t5 exh", 64'(exhausted), 64'b1110);
    tick; set(0, 0, 0, 0, 4'h0);
    @(negedge clk);
    check("t5 running", 64'(running), 64'h0);
    // mid-operation reset
    tick; set(1, 0, 1, 100, 4'h0);
    tick; set(0, 0, 0, 0, 4'hF);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    @(negedge clk);
    check("t6 ready", 64'(req_ready), 64'h0);
    check("t6 running", 64'(running), 64'h0);
    check("t6 all_done", 64'(all_done), 64'h0);
    tick; set(1, 7, 0, 7, 4'h0);
    tick; set(0, 0, 0, 0, 4'hF);
    @(negedge clk);
    check("t6 running exh", 64'(running), 64'h0);
    check("t6 exh", 64'(exhausted), 64'hF);
    check("t6 c2", 64'(gc_out[2]), 64'd7);
    tick; set(0, 0, 0, 0, 4'h0);
    @(negedge clk);
    check("t6 all_done", 64'(all_done), 64'h1);
    tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
